// File: rtl/sysid_probe_pkg.sv
// sysid_probe_pkg
// Shared definitions for the system-ID probe master: FSM state encoding,
// Avalon word addresses of the ID and timestamp registers, and the width
// of the shared wait/timeout counter.
package sysid_probe_pkg;

  localparam int CTR_W = 8;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ID   = 3'd1,
    S_WAIT_ID = 3'd2,
    S_RD_TS   = 3'd3,
    S_WAIT_TS = 3'd4,
    S_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/sysid_probe_wait_ctr.sv
// sysid_probe_wait_ctr
// Loadable down-counter that saturates at zero. The probe FSM uses it both
// for the fixed read-latency wait and for the waitrequest stall timeout;
// the two never overlap.
// Ports:
//   clock, reset  rising-edge clock, async active-high reset
//   load          load load_value (takes priority over dec)
//   load_value    value to load
//   dec           decrement by one when non-zero
//   count         current value
//   zero          count == 0
module sysid_probe_wait_ctr
  import sysid_probe_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CTR_W-1:0] load_value,
  input  logic             dec,
  output logic [CTR_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sysid_probe_master.sv
// sysid_probe_master
// Avalon-MM read initiator that fetches the system-ID word (address 0) and
// the build timestamp (address 1), compares them against build-time values
// and reports match / stall-timeout status.
//
// FSM states:
//   state     | meaning
//   S_IDLE    | waiting for start or pending auto-start
//   S_RD_ID   | read strobe on address 0 until accepted or timed out
//   S_WAIT_ID | counting read latency for the ID word
//   S_RD_TS   | read strobe on address 1 until accepted or timed out
//   S_WAIT_TS | counting read latency for the timestamp word
//   S_DONE    | one-cycle completion pulse
//
// Ports:
//   clock, reset       rising-edge clock, async active-high reset
//   start              probe request, honoured only in S_IDLE
//   address, read      Avalon-MM master request
//   waitrequest        slave stall
//   readdata           slave read data
//   busy, done         probe in progress / completion pulse
//   id_ok, ts_ok       comparison results
//   timeout            probe aborted by stall timeout
//   id_value, timestamp_value  captured words
module sysid_probe_master
  import sysid_probe_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1328261165,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value
);

  localparam bit LAT_EN = (READ_LATENCY > 0);
  localparam bit TO_EN  = (TIMEOUT_CYCLES > 0);
  // Both loads are "N-1": the counter hits zero on the Nth cycle.
  localparam logic [CTR_W-1:0] LAT_LOAD = CTR_W'(LAT_EN ? READ_LATENCY - 1 : 0);
  localparam logic [CTR_W-1:0] TO_LOAD  = CTR_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_t           state, state_next;
  logic             auto_pend;
  logic             go, cap_id, cap_ts, to_hit;
  logic             ctr_load, ctr_dec, ctr_zero;
  logic [CTR_W-1:0] ctr_val, ctr_count;

  sysid_probe_wait_ctr u_ctr (
    .clock      (clock),
    .reset      (reset),
    .load       (ctr_load),
    .load_value (ctr_val),
    .dec        (ctr_dec),
    .count      (ctr_count),
    .zero       (ctr_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    go         = 1'b0;
    cap_id     = 1'b0;
    cap_ts     = 1'b0;
    to_hit     = 1'b0;
    ctr_load   = 1'b0;
    ctr_val    = TO_LOAD;
    ctr_dec    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start || auto_pend) begin
          go         = 1'b1;
          ctr_load   = 1'b1;
          state_next = S_RD_ID;
        end
      end
      S_RD_ID, S_RD_TS: begin
        if (!waitrequest) begin
          ctr_load = 1'b1;
          if (LAT_EN) begin
            ctr_val    = LAT_LOAD;
            state_next = (state == S_RD_ID) ? S_WAIT_ID : S_WAIT_TS;
          end else if (state == S_RD_ID) begin
            cap_id     = 1'b1;
            state_next = S_RD_TS;
          end else begin
            cap_ts     = 1'b1;
            state_next = S_DONE;
          end
        end else if (TO_EN && ctr_zero) begin
          to_hit     = 1'b1;
          state_next = S_DONE;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      S_WAIT_ID: begin
        if (ctr_zero) begin
          cap_id     = 1'b1;
          ctr_load   = 1'b1;
          state_next = S_RD_TS;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      S_WAIT_TS: begin
        if (ctr_zero) begin
          cap_ts     = 1'b1;
          state_next = S_DONE;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Pure state decode keeps read/address/busy free of input paths.
  always_comb begin
    read    = (state == S_RD_ID) || (state == S_RD_TS);
    address = ((state == S_RD_TS) || (state == S_WAIT_TS)) ? ADDR_TS : ADDR_ID;
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      auto_pend       <= AUTO_START;
      id_ok           <= 1'b0;
      ts_ok           <= 1'b0;
      timeout         <= 1'b0;
      id_value        <= '0;
      timestamp_value <= '0;
    end else begin
      if (go) begin
        auto_pend       <= 1'b0;
        id_ok           <= 1'b0;
        ts_ok           <= 1'b0;
        timeout         <= 1'b0;
        id_value        <= '0;
        timestamp_value <= '0;
      end
      if (cap_id) begin
        id_value <= readdata;
        id_ok    <= (readdata == EXPECTED_ID);
      end
      if (cap_ts) begin
        timestamp_value <= readdata;
        ts_ok           <= (readdata == EXPECTED_TIMESTAMP);
      end
      if (to_hit) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sysid_probe_master.sv
module tb_sysid_probe_master;

  localparam logic [31:0] TS = 32'd1328261165;

  typedef struct {
    logic        id_ok;
    logic        ts_ok;
    logic        tmo;
    logic [31:0] idv;
    logic [31:0] tsv;
    int          done_edge;
    int          reads;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  exp_t q0[$];
  exp_t q2[$];
  exp_t e0, e2;

  // ---------------- DUT 0: zero read latency, stall-capable slave ----------------
  logic rst0 = 1'b1, start0 = 1'b0;
  logic addr0, rd0, wr0, busy0, done0, idok0, tsok0, tmo0;
  logic [31:0] rdata0, idv0, tsv0;
  logic [31:0] id0_data = 32'd0;
  int nstall0 = 0, stall_cnt0 = 0;

  assign wr0    = rd0 && (stall_cnt0 != nstall0);
  assign rdata0 = addr0 ? TS : id0_data;
  always @(posedge clk) stall_cnt0 <= (rd0 && wr0) ? stall_cnt0 + 1 : 0;

  sysid_probe_master #(.READ_LATENCY(0), .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)) u0 (
    .clock(clk), .reset(rst0), .start(start0), .address(addr0), .read(rd0),
    .waitrequest(wr0), .readdata(rdata0), .busy(busy0), .done(done0),
    .id_ok(idok0), .ts_ok(tsok0), .timeout(tmo0), .id_value(idv0),
    .timestamp_value(tsv0));

  // ---------------- DUT 2: read latency 2, zero-wait slave ----------------
  logic rst2 = 1'b1, start2 = 1'b0;
  logic addr2, rd2, busy2, done2, idok2, tsok2, tmo2;
  logic wr2 = 1'b0;
  logic [31:0] rdata2, idv2, tsv2;
  logic [1:0] p1, p2;

  always @(posedge clk or posedge rst2) begin
    if (rst2) begin
      p1 <= 2'b00;
      p2 <= 2'b00;
    end else begin
      p1 <= {rd2 && !wr2, addr2};
      p2 <= p1;
    end
  end
  assign rdata2 = p2[1] ? (p2[0] ? TS : 32'd0) : 32'hDEADBEEF;

  sysid_probe_master #(.READ_LATENCY(2), .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)) u2 (
    .clock(clk), .reset(rst2), .start(start2), .address(addr2), .read(rd2),
    .waitrequest(wr2), .readdata(rdata2), .busy(busy2), .done(done2),
    .id_ok(idok2), .ts_ok(tsok2), .timeout(tmo2), .id_value(idv2),
    .timestamp_value(tsv2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag, input logic r, input logic a, input logic b,
                          input logic d, input logic io, input logic tso, input logic tm,
                          input logic [31:0] iv, input logic [31:0] tv);
    chk({tag, "_read"}, 32'(r), 0);
    chk({tag, "_address"}, 32'(a), 0);
    chk({tag, "_busy"}, 32'(b), 0);
    chk({tag, "_done"}, 32'(d), 0);
    chk({tag, "_id_ok"}, 32'(io), 0);
    chk({tag, "_ts_ok"}, 32'(tso), 0);
    chk({tag, "_timeout"}, 32'(tm), 0);
    chk({tag, "_id_value"}, iv, 0);
    chk({tag, "_ts_value"}, tv, 0);
  endtask

  function automatic exp_t mk(input logic io, input logic tso, input logic tm,
                              input logic [31:0] iv, input logic [31:0] tv,
                              input int de, input int rds);
    exp_t e;
    e.id_ok = io; e.ts_ok = tso; e.tmo = tm; e.idv = iv; e.tsv = tv;
    e.done_edge = de; e.reads = rds;
    return e;
  endfunction

  task automatic wait_q(input int which, input int budget);
    int n = 0;
    while (((which == 0) ? q0.size() : q2.size()) != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_done_u%0d: no done within %0d cycles", which, budget);
      if (which == 0) q0.delete(); else q2.delete();
    end
  endtask

  // ---------------- monitors ----------------
  int nrd0 = 0, ndone0 = 0, paddr0 = 0;
  logic pst0 = 1'b0, pdone0 = 1'b0;
  always @(negedge clk) begin
    if (rst0) begin
      nrd0 = 0; pst0 = 1'b0; pdone0 = 1'b0;
    end else begin
      if (pst0 && rd0) chk("u0_addr_stable", 32'(addr0), 32'(paddr0));
      if (rd0) nrd0++;
      if (done0) begin
        ndone0++;
        chk("u0_done_one_cycle", 32'(pdone0), 0);
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL u0_unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          e0 = q0.pop_front();
          chk("u0_done_edge", cyc + 1, e0.done_edge);
          chk("u0_id_ok", 32'(idok0), 32'(e0.id_ok));
          chk("u0_ts_ok", 32'(tsok0), 32'(e0.ts_ok));
          chk("u0_timeout", 32'(tmo0), 32'(e0.tmo));
          chk("u0_id_value", idv0, e0.idv);
          chk("u0_ts_value", tsv0, e0.tsv);
          chk("u0_read_cycles", nrd0, e0.reads);
          chk("u0_busy_in_done", 32'(busy0), 1);
        end
        nrd0 = 0;
      end
      pst0 = rd0 && wr0; paddr0 = 32'(addr0); pdone0 = done0;
    end
  end

  int nrd2 = 0, ndone2 = 0;
  logic pdone2 = 1'b0;
  always @(negedge clk) begin
    if (rst2) begin
      nrd2 = 0; pdone2 = 1'b0;
    end else begin
      if (rd2) nrd2++;
      if (done2) begin
        ndone2++;
        chk("u2_done_one_cycle", 32'(pdone2), 0);
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL u2_unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          e2 = q2.pop_front();
          chk("u2_done_edge", cyc + 1, e2.done_edge);
          chk("u2_id_ok", 32'(idok2), 32'(e2.id_ok));
          chk("u2_ts_ok", 32'(tsok2), 32'(e2.ts_ok));
          chk("u2_timeout", 32'(tmo2), 32'(e2.tmo));
          chk("u2_id_value", idv2, e2.idv);
          chk("u2_ts_value", tsv2, e2.tsv);
          chk("u2_read_cycles", nrd2, e2.reads);
        end
        nrd2 = 0;
      end
      pdone2 = done2;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("u0_reset", rd0, addr0, busy0, done0, idok0, tsok0, tmo0, idv0, tsv0);
    chk_zero("u2_reset", rd2, addr2, busy2, done2, idok2, tsok2, tmo2, idv2, tsv2);

    // auto-start, zero wait, matching data
    rst0 = 1'b0;
    q0.push_back(mk(1, 1, 0, 32'd0, TS, cyc + 1 + 3, 2));
    wait_q(0, 50);

    // ID mismatch
    @(posedge clk); #1;
    id0_data = 32'd1;
    start0 = 1'b1;
    q0.push_back(mk(0, 1, 0, 32'd1, TS, cyc + 1 + 3, 2));
    @(posedge clk); #1;
    start0 = 1'b0;
    wait_q(0, 50);

    // 10 stall cycles per read; status clears at start acceptance
    @(posedge clk); #1;
    id0_data = 32'd0;
    nstall0 = 10;
    start0 = 1'b1;
    q0.push_back(mk(1, 1, 0, 32'd0, TS, cyc + 1 + 23, 22));
    @(posedge clk); #1;
    start0 = 1'b0;
    chk("u0_clear_id_value", idv0, 0);
    chk("u0_clear_ts_ok", 32'(tsok0), 0);
    chk("u0_busy_after_start", 32'(busy0), 1);
    wait_q(0, 80);

    // stall past timeout on the ID read
    @(posedge clk); #1;
    nstall0 = 300;
    start0 = 1'b1;
    q0.push_back(mk(0, 0, 1, 32'd0, 32'd0, cyc + 1 + 256, 255));
    @(posedge clk); #1;
    start0 = 1'b0;
    wait_q(0, 400);
    nstall0 = 0;

    // latency-2 DUT: auto-start
    @(posedge clk); #1;
    rst2 = 1'b0;
    q2.push_back(mk(1, 1, 0, 32'd0, TS, cyc + 1 + 7, 2));
    wait_q(2, 50);

    // start, then reset during WAIT_TS
    @(posedge clk); #1;
    start2 = 1'b1;
    q2.push_back(mk(1, 1, 0, 32'd0, TS, cyc + 1 + 7, 2));
    @(posedge clk); #1;
    start2 = 1'b0;
    n = 0;
    while (!(busy2 && addr2 && !rd2) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("u2_reached_wait_ts", 32'(n < 20), 1);
    rst2 = 1'b1;
    q2.delete();
    #1;
    chk_zero("u2_midreset", rd2, addr2, busy2, done2, idok2, tsok2, tmo2, idv2, tsv2);
    @(posedge clk); #1;
    chk("u2_read_in_reset", 32'(rd2), 0);
    rst2 = 1'b0;
    q2.push_back(mk(1, 1, 0, 32'd0, TS, cyc + 1 + 7, 2));
    @(posedge clk); #1;
    @(posedge clk); #1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    wait_q(2, 50);
    repeat (15) @(posedge clk);
    #1;
    chk("u0_done_count", ndone0, 4);
    chk("u2_done_count", ndone2, 2);
    chk("u2_idle_after", 32'(busy2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sysid_probe_master.md
# sysid_probe_master

Avalon-MM read initiator for the system-ID slave. After reset (or on `start`) it reads the ID word (address 0), then the timestamp word (address 1). It compares both against build-time expected values and reports match/timeout status. It sits beside the Nios/Qsys interconnect as a self-check that the loaded FPGA image matches the software build.

## Interface
Parameters:
- `EXPECTED_ID`, 0, expected ID word at address 0.
- `EXPECTED_TIMESTAMP`, 1328261165, expected timestamp word at address 1.
- `READ_LATENCY`, 0, fixed slave read latency in cycles (0..7); 0 = `readdata` valid in the accept cycle.
- `TIMEOUT_CYCLES`, 255, maximum consecutive `waitrequest` stall cycles per read (1..255); 0 disables the timeout.
- `AUTO_START`, 1, 1 = run one probe automatically after reset.

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to run a probe; ignored while `busy`.
- `address`  out  1  Avalon-MM word address.
- `read`  out  1  Avalon-MM read strobe.
- `waitrequest`  in  1  slave stall; tie to 0 for zero-wait slaves.
- `readdata`  in  32  slave read data.
- `busy`  out  1  high from start acceptance through the DONE cycle.
- `done`  out  1  one-cycle pulse at the end of a probe.
- `id_ok`  out  1  captured ID equals `EXPECTED_ID`.
- `ts_ok`  out  1  captured timestamp equals `EXPECTED_TIMESTAMP`.
- `timeout`  out  1  the probe was aborted by a stall timeout.
- `id_value`  out  32  captured ID word.
- `timestamp_value`  out  32  captured timestamp word.

## Operation
- FSM states: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE.
- IDLE → RD_ID on `start` or on the pending auto-start flag. On this edge, clear `id_ok`, `ts_ok`, `timeout`, `id_value` and `timestamp_value`.
- The auto-start flag resets to `AUTO_START` and clears when the first probe is accepted.
- RD_ID / RD_TS drive `read`=1 and `address` = 0 / 1 respectively.
  - A read is accepted on the edge where `read`=1 and `waitrequest`=0.
  - On acceptance, go to the WAIT state if `READ_LATENCY`>0, else capture `readdata` on the same edge and advance.
- WAIT_ID / WAIT_TS drive `read`=0 and hold `address`.
  - Count `READ_LATENCY` cycles, then capture `readdata` and advance.
  - WAIT_ID advances to RD_TS; WAIT_TS advances to DONE.
- On ID capture, register `id_ok` = (`readdata` == `EXPECTED_ID`). On timestamp capture, register `ts_ok` likewise against `EXPECTED_TIMESTAMP`.
- Timeout:
  - The stall counter resets on entry to each RD state and increments each cycle with `read` & `waitrequest`.
  - When the counter reaches `TIMEOUT_CYCLES`, drop `read`, set `timeout`=1, leave the remaining `*_ok` at 0, and go to DONE.
- DONE: `done`=1 for exactly one cycle, then return to IDLE. Status outputs hold until the next accepted start.
- `start` while `busy` is ignored; it is not queued.
- `start` in the DONE cycle is also ignored.

## Timing
- Reset values: `read`, `address`, `busy`, `done`, `id_ok`, `ts_ok`, `timeout` = 0; `id_value` and `timestamp_value` = 0; state = IDLE.
- `read`, `address` and `busy` decode from registered state with no input-to-output combinational path. `read` is never high during reset.
- Total latency with zero stalls: `done` goes high 3 + 2·`READ_LATENCY` cycles after the edge that samples `start`. Each stall cycle adds 1.
- With `AUTO_START`=1, the first rising edge after `reset` deasserts acts as the start edge.
- Reset asserted mid-probe:
  - All outputs return to their reset values immediately.
  - The auto-start flag reloads, so a probe reruns after release if `AUTO_START`=1.
- `address` is stable for the whole RD and WAIT interval of each read.

## Structure
- Package `sysid_probe_pkg`: FSM state enum, `ADDR_ID` = 0 and `ADDR_TS` = 1 constants, and the 8-bit counter width constant.
- Sub-module `sysid_probe_wait_ctr`: a loadable 8-bit down-counter with a `zero` flag. It is shared for read-latency wait and stall timeout, since only one is active at a time.
- Top level: FSM, capture registers and comparators.

## Test plan
- `AUTO_START`=1, zero-wait slave returning 0 at addr 0 and 1328261165 at addr 1, `READ_LATENCY`=0, defaults → `done` 3 cycles after the start edge; `id_ok`=1, `ts_ok`=1, `timeout`=0, `timestamp_value`=1328261165.
- Slave returns 0x00000001 at addr 0 → `id_ok`=0, `ts_ok`=1, `id_value`=1; on the next `start`, status clears before recapture.
- `READ_LATENCY`=2, slave data valid 2 cycles after accept → `done` at cycle 7; both `*_ok`=1; `read` high exactly 1 cycle per word.
- `waitrequest` held high 300 cycles on the ID read, `TIMEOUT_CYCLES`=255 → `read` drops after 255 stall cycles; `timeout`=1, `id_ok`=`ts_ok`=0, one `done` pulse.
- `waitrequest` high 10 cycles per read → `done` at cycle 23; results correct; `address` stable throughout each stall.
- `reset` pulsed during WAIT_TS; `start` pulsed while busy → outputs zero during reset; the probe reruns after release; the mid-probe `start` does not queue a second `done`.
